// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared types and constants for the router address generator.
// Revision    : 1.0
// ============================================================================
package router_pkg;

    localparam int AG_ADDR_WIDTH  = 6;
    localparam int AG_SA_BITS     = 2;
    localparam int AG_KERNEL_SIZE = 3;
    localparam int K2             = AG_KERNEL_SIZE * AG_KERNEL_SIZE;
    localparam int K2_BITS        = $clog2(K2);

    typedef enum logic [0:0] {
        AG_IDLE  = 1'b0,
        AG_FETCH = 1'b1
    } ag_state_t;

    typedef struct packed {
        logic [AG_ADDR_WIDTH-1:0] x;
        logic [AG_ADDR_WIDTH-1:0] y;
        logic [AG_SA_BITS-1:0]    row;
    } ag_req_t;

    // Index width that never collapses to zero bits.
    function automatic int bits_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : router_req_fifo
// Description : Synchronous request FIFO (ag_req_t) with flush, full/empty.
// Revision    : 1.0
// ============================================================================
module router_req_fifo
    import router_pkg::*;
#(
    parameter int REQ_DEPTH = 4
)
(
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_flush,
    input  logic    i_push,
    input  ag_req_t i_wdata,
    input  logic    i_pop,
    output ag_req_t o_rdata,
    output logic    o_full,
    output logic    o_empty
);

    localparam int PTR_BITS = bits_of(REQ_DEPTH);

    ag_req_t               r_mem [REQ_DEPTH];
    logic [PTR_BITS-1:0]   r_wptr;
    logic [PTR_BITS-1:0]   r_rptr;
    logic [PTR_BITS:0]     r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == (PTR_BITS+1)'(REQ_DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_BITS'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_BITS'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_BITS+1)'(1);
                2'b01:   r_count <= r_count - (PTR_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : router_addr_gen
// Description : Expands queued output-pixel requests into kernel-window SRAM
//               reads and writes the returned activations to SA row buffers.
// Revision    : 1.0
// ============================================================================
module router_addr_gen
    import router_pkg::*;
#(
    parameter int SA_HEIGHT   = 4,
    parameter int KERNEL_SIZE = AG_KERNEL_SIZE,
    parameter int ADDR_WIDTH  = AG_ADDR_WIDTH,
    parameter int DATA_WIDTH  = 8,
    parameter int REQ_DEPTH   = 4,
    localparam int SA_BITS    = bits_of(SA_HEIGHT),
    localparam int IDX_BITS   = (KERNEL_SIZE == AG_KERNEL_SIZE) ? K2_BITS
                                : bits_of(KERNEL_SIZE * KERNEL_SIZE)
)
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_reg_clear,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_x,
    input  logic [ADDR_WIDTH-1:0] i_req_y,
    input  logic [SA_BITS-1:0]    i_req_row,
    output logic                  o_req_ready,
    output logic                  o_sram_ren,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    input  logic [DATA_WIDTH-1:0] i_sram_rdata,
    output logic                  o_rb_wr_en,
    output logic [SA_BITS-1:0]    o_rb_row,
    output logic [IDX_BITS-1:0]   o_rb_idx,
    output logic [DATA_WIDTH-1:0] o_rb_wdata,
    output logic                  o_row_done,
    output logic                  o_idle,
    output logic                  o_overflow
);

    localparam int                    KIDX_BITS = bits_of(KERNEL_SIZE);
    localparam logic [KIDX_BITS-1:0]  K_LAST    = KIDX_BITS'(KERNEL_SIZE - 1);

    ag_req_t               w_fifo_in;
    ag_req_t               w_fifo_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    ag_state_t             r_state;
    ag_state_t             w_nxt_state;
    ag_req_t               r_cur;
    ag_req_t               w_nxt_cur;
    logic [KIDX_BITS-1:0]  r_kx;
    logic [KIDX_BITS-1:0]  r_ky;
    logic [KIDX_BITS-1:0]  w_nxt_kx;
    logic [KIDX_BITS-1:0]  w_nxt_ky;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_nxt_addr;
    logic [IDX_BITS-1:0]   w_idx;
    logic                  w_win_last;

    logic                  r_pl_valid;
    logic                  r_pl_last;
    logic [SA_BITS-1:0]    r_pl_row;
    logic [IDX_BITS-1:0]   r_pl_idx;
    logic                  r_ovf;

    assign w_fifo_in = '{x:   AG_ADDR_WIDTH'(i_req_x),
                         y:   AG_ADDR_WIDTH'(i_req_y),
                         row: AG_SA_BITS'(i_req_row)};
    assign w_push    = i_req_valid && !w_full && !i_reg_clear;

    router_req_fifo #(
        .REQ_DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_reg_clear),
        .i_push  (w_push),
        .i_wdata (w_fifo_in),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_win_last = (r_kx == K_LAST) && (r_ky == K_LAST);
    assign w_idx      = IDX_BITS'(r_kx) * IDX_BITS'(KERNEL_SIZE) + IDX_BITS'(r_ky);

    // Window walk: ky fastest; the last element chains straight into the next request.
    always_comb begin
        w_pop       = 1'b0;
        w_nxt_state = r_state;
        w_nxt_cur   = r_cur;
        w_nxt_kx    = r_kx;
        w_nxt_ky    = r_ky;
        case (r_state)
            AG_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_nxt_cur   = w_fifo_head;
                    w_nxt_kx    = '0;
                    w_nxt_ky    = '0;
                    w_nxt_state = AG_FETCH;
                end
            end
            AG_FETCH: begin
                if (r_ky != K_LAST) begin
                    w_nxt_ky = r_ky + KIDX_BITS'(1);
                end else begin
                    w_nxt_ky = '0;
                    if (r_kx != K_LAST) begin
                        w_nxt_kx = r_kx + KIDX_BITS'(1);
                    end else begin
                        w_nxt_kx = '0;
                        if (!w_empty) begin
                            w_pop     = 1'b1;
                            w_nxt_cur = w_fifo_head;
                        end else begin
                            w_nxt_state = AG_IDLE;
                        end
                    end
                end
            end
            default: w_nxt_state = AG_IDLE;
        endcase
    end

    // Evaluated at ADDR_WIDTH bits so the address wraps modulo 2^ADDR_WIDTH.
    assign w_nxt_addr = i_start_addr
                      + (ADDR_WIDTH'(w_nxt_cur.x) + ADDR_WIDTH'(w_nxt_kx)) * i_i_size
                      + ADDR_WIDTH'(w_nxt_cur.y) + ADDR_WIDTH'(w_nxt_ky);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= AG_IDLE;
            r_cur      <= '0;
            r_kx       <= '0;
            r_ky       <= '0;
            r_addr     <= '0;
            r_pl_valid <= 1'b0;
            r_pl_last  <= 1'b0;
            r_pl_row   <= '0;
            r_pl_idx   <= '0;
            r_ovf      <= 1'b0;
        end else if (i_reg_clear) begin
            r_state    <= AG_IDLE;
            r_cur      <= '0;
            r_kx       <= '0;
            r_ky       <= '0;
            r_addr     <= '0;
            r_pl_valid <= 1'b0;
            r_pl_last  <= 1'b0;
            r_pl_row   <= '0;
            r_pl_idx   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cur      <= w_nxt_cur;
            r_kx       <= w_nxt_kx;
            r_ky       <= w_nxt_ky;
            r_addr     <= (w_nxt_state == AG_FETCH) ? w_nxt_addr : '0;
            r_pl_valid <= (r_state == AG_FETCH);
            if (r_state == AG_FETCH) begin
                r_pl_row  <= SA_BITS'(r_cur.row);
                r_pl_idx  <= w_idx;
                r_pl_last <= w_win_last;
            end
            r_ovf      <= r_ovf | (i_req_valid & w_full);
        end
    end

    assign o_req_ready = !w_full;
    assign o_sram_ren  = (r_state == AG_FETCH);
    assign o_sram_addr = r_addr;
    assign o_rb_wr_en  = r_pl_valid;
    assign o_rb_row    = r_pl_row;
    assign o_rb_idx    = r_pl_idx;
    assign o_rb_wdata  = r_pl_valid ? i_sram_rdata : '0;
    assign o_row_done  = r_pl_valid & r_pl_last;
    assign o_idle      = w_empty && (r_state == AG_IDLE) && !r_pl_valid;
    assign o_overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_router_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_addr_gen
// Description : Self-checking bench for router_addr_gen against a queue model.
// Revision    : 1.0
// ============================================================================
module tb_router_addr_gen;

    localparam int DEPTH = 4;
    localparam int KS    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       valid = 1'b0;
    logic [5:0] start = '0;
    logic [5:0] isize = 6'd6;
    logic [5:0] rx = '0;
    logic [5:0] ry = '0;
    logic [1:0] rrow = '0;
    logic [7:0] rdata = '0;

    logic       ready, ren, wr_en, done, idle, ovf;
    logic [5:0] addr;
    logic [1:0] rb_row;
    logic [3:0] rb_idx;
    logic [7:0] wdata;

    router_addr_gen dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_reg_clear  (clear),
        .i_start_addr (start),
        .i_i_size     (isize),
        .i_req_valid  (valid),
        .i_req_x      (rx),
        .i_req_y      (ry),
        .i_req_row    (rrow),
        .o_req_ready  (ready),
        .o_sram_ren   (ren),
        .o_sram_addr  (addr),
        .i_sram_rdata (rdata),
        .o_rb_wr_en   (wr_en),
        .o_rb_row     (rb_row),
        .o_rb_idx     (rb_idx),
        .o_rb_wdata   (wdata),
        .o_row_done   (done),
        .o_idle       (idle),
        .o_overflow   (ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: pending requests, the remaining reads of the active window, and
    // the read whose data is being written this cycle.
    typedef struct { int x; int y; int row; } req_t;
    typedef struct { int addr; int row; int idx; bit last; } rd_t;

    req_t pend[$];
    rd_t  rdq[$];
    rd_t  wr_e;
    bit   wr_v  = 1'b0;
    bit   m_ovf = 1'b0;
    int   m_pre;
    int   cyc = 0;

    function automatic void expand(input req_t r);
        for (int kx = 0; kx < KS; kx++) begin
            for (int ky = 0; ky < KS; ky++) begin
                rd_t e;
                e.addr = (int'(start) + (r.x + kx) * int'(isize) + r.y + ky) % 64;
                e.row  = r.row;
                e.idx  = kx * KS + ky;
                e.last = (kx == KS - 1) && (ky == KS - 1);
                rdq.push_back(e);
            end
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete();
            rdq.delete();
            wr_v  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            cyc++;
            if (clear) begin
                pend.delete();
                rdq.delete();
                wr_v  = 1'b0;
                m_ovf = 1'b0;
            end else begin
                m_pre = pend.size();
                wr_v  = 1'b0;
                if (rdq.size() > 0) begin
                    wr_v = 1'b1;
                    wr_e = rdq.pop_front();
                end
                if (rdq.size() == 0 && pend.size() > 0) begin
                    expand(pend.pop_front());
                end
                if (valid) begin
                    if (m_pre < DEPTH) pend.push_back('{x: int'(rx), y: int'(ry), row: int'(rrow)});
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    int rd_log[$];
    int rd_cyc[$];
    int done_cyc[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("ren", ren, rdq.size() > 0);
            if (rdq.size() > 0) chk("addr", addr, rdq[0].addr);
            chk("wr_en", wr_en, wr_v);
            if (wr_v) begin
                chk("rb_row", rb_row, wr_e.row);
                chk("rb_idx", rb_idx, wr_e.idx);
                chk("rb_wdata", wdata, rdata);
            end
            chk("row_done", done, wr_v && wr_e.last);
            chk("ready", ready, pend.size() < DEPTH);
            chk("idle", idle, pend.size() == 0 && rdq.size() == 0 && !wr_v);
            chk("overflow", ovf, m_ovf);
            if (ren === 1'b1) begin
                rd_log.push_back(int'(addr));
                rd_cyc.push_back(cyc);
            end
            if (done === 1'b1) done_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rdata = 8'($urandom);
    endtask

    task automatic idle_n(input int n);
        valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input int x, input int y, input int row);
        valid = 1'b1;
        rx    = 6'(x);
        ry    = 6'(y);
        rrow  = 2'(row);
        step();
        valid = 1'b0;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        rd_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ren"}, ren, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ovf"}, ovf, 0);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_idle"}, idle, 1);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_row"}, rb_row, 0);
        chk({tag, "_idx"}, rb_idx, 0);
        chk({tag, "_wdata"}, wdata, 0);
    endtask

    int t0;
    int exp1[9] = '{8, 9, 10, 14, 15, 16, 20, 21, 22};
    int exp4[9] = '{60, 61, 62, 4, 5, 6, 12, 13, 14};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rdata = 8'hA5;
        #1;
        check_reset("por");
        rst = 1'b0;
        step();

        // Single window, start=0, i_size=6, (1,2) into row 3.
        start = 6'd0;
        isize = 6'd6;
        clear_logs();
        send(1, 2, 3);
        t0 = cyc;
        idle_n(14);
        chk("t1_nreads", rd_log.size(), 9);
        for (int i = 0; i < 9; i++) chk("t1_addr", rd_log[i], exp1[i]);
        chk("t1_first_read_lat", rd_cyc[0] - t0, 1);
        chk("t1_ndone", done_cyc.size(), 1);
        chk("t1_done_lat", done_cyc[0] - t0, 10);

        // Four back-to-back requests: contiguous reads, done pulses 9 apart.
        clear_logs();
        for (int r = 0; r < 4; r++) send(r, r + 1, r);
        idle_n(45);
        chk("t2_nreads", rd_log.size(), 36);
        chk("t2_contiguous", rd_cyc[35] - rd_cyc[0], 35);
        chk("t2_ndone", done_cyc.size(), 4);
        for (int i = 1; i < 4; i++) chk("t2_done_gap", done_cyc[i] - done_cyc[i-1], 9);

        // Seven consecutive valids: one popped immediately, four queued, two dropped.
        clear_logs();
        for (int i = 0; i < 7; i++) send($urandom_range(0, 63), $urandom_range(0, 63), i % 4);
        chk("t3_overflow_set", ovf, 1);
        idle_n(60);
        chk("t3_ndone", done_cyc.size(), 5);
        chk("t3_overflow_sticky", ovf, 1);

        // Address wrap modulo 64.
        start = 6'd60;
        isize = 6'd8;
        clear_logs();
        send(0, 0, 1);
        idle_n(12);
        chk("t4_nreads", rd_log.size(), 9);
        for (int i = 0; i < 9; i++) chk("t4_addr", rd_log[i], exp4[i]);

        // Synchronous clear after the fourth read.
        start = 6'd0;
        isize = 6'd6;
        clear_logs();
        send(1, 1, 2);
        repeat (4) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t5_wr_en", wr_en, 0);
        chk("t5_ren", ren, 0);
        chk("t5_idle", idle, 1);
        chk("t5_ovf_cleared", ovf, 0);
        chk("t5_nreads", rd_log.size(), 4);
        clear_logs();
        send(2, 1, 0);
        idle_n(12);
        chk("t5_restart_addr", rd_log[0], 13);
        chk("t5_restart_nreads", rd_log.size(), 9);

        // Asynchronous reset mid-request with a full queue and overflow set.
        for (int i = 0; i < 7; i++) send($urandom_range(0, 63), $urandom_range(0, 63), i % 4);
        step();
        #2;
        rdata = 8'h5A;
        rst   = 1'b1;
        #1;
        check_reset("arst");
        step();
        step();
        rst = 1'b0;
        step();

        // Randomized traffic in epochs with a fixed base address and map size.
        for (int ep = 0; ep < 4; ep++) begin
            start = 6'($urandom);
            isize = 6'($urandom);
            for (int n = 0; n < 150; n++) begin
                valid = ($urandom_range(0, 99) < 45);
                rx    = 6'($urandom);
                ry    = 6'($urandom);
                rrow  = 2'($urandom);
                clear = ($urandom_range(0, 79) == 0);
                step();
            end
            clear = 1'b0;
            idle_n(60);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
